// File: rtl/mem_arbiter.sv
// Shared-memory request arbiter with a tagged, fixed-latency response pipe.
// Define MEM_ARB_RR_EN for round-robin; otherwise the lowest port index wins.
module mem_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int NPORTS  = 2,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid_i,
  output logic [NPORTS-1:0]        req_ready_o,
  input  logic [NPORTS*AWIDTH-1:0] req_addr_i,
  input  logic [NPORTS*DWIDTH-1:0] req_wdata_i,
  input  logic [NPORTS-1:0]        req_we_i,
  input  logic [NPORTS*3-1:0]      req_funct3_i,
  output logic [NPORTS-1:0]        rsp_valid_o,
  output logic [DWIDTH-1:0]        rsp_data_o,
  output logic [AWIDTH-1:0]        mem_addr_o,
  output logic [DWIDTH-1:0]        mem_data_o,
  output logic                     mem_read_en_o,
  output logic                     mem_write_en_o,
  output logic [2:0]               mem_funct3_o,
  input  logic [DWIDTH-1:0]        mem_data_i
);

  localparam int IW = $clog2(NPORTS);

  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     win_id;
  logic              win_any;
  logic [NPORTS-1:0] grant;

  logic              pv  [LATENCY];
  logic [IW-1:0]     pid [LATENCY];
  logic [DWIDTH-1:0] pd  [LATENCY];

`ifdef MEM_ARB_RR_EN
  // Round-robin: ports above last_grant first, then wrap to the low ones.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (!win_any && req_valid_i[j] && (j > int'(last_grant))) begin
        win_any = 1'b1;
        win_id  = IW'(j);
      end
    end
    for (int j = 0; j < NPORTS; j++) begin
      if (!win_any && req_valid_i[j] && (j <= int'(last_grant))) begin
        win_any = 1'b1;
        win_id  = IW'(j);
      end
    end
    if (rst) begin
      win_any = 1'b0;
      win_id  = '0;
    end
  end
`else
  // Fixed priority: lowest valid index wins, so data beats fetch.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int j = 0; j < NPORTS; j++) begin
      if (!win_any && req_valid_i[j]) begin
        win_any = 1'b1;
        win_id  = IW'(j);
      end
    end
    if (rst) begin
      win_any = 1'b0;
      win_id  = '0;
    end
  end
`endif

  assign grant       = win_any ? (NPORTS'(1) << win_id) : '0;
  assign req_ready_o = grant;

  // Steer the winner's payload onto the memory port; idle drives zeros.
  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_funct3_o   = '0;
    mem_write_en_o = 1'b0;
    mem_read_en_o  = 1'b0;
    for (int j = 0; j < NPORTS; j++) begin
      if (grant[j]) begin
        mem_addr_o     = req_addr_i[j*AWIDTH +: AWIDTH];
        mem_data_o     = req_wdata_i[j*DWIDTH +: DWIDTH];
        mem_funct3_o   = req_funct3_i[j*3 +: 3];
        mem_write_en_o = req_we_i[j];
        mem_read_en_o  = ~req_we_i[j];
      end
    end
  end

  // Priority pointer follows each accept; holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(NPORTS - 1);
    end else begin
      last_grant <= win_any ? win_id : last_grant;
    end
  end

  // Response pipe: capture the accept, then shift unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv[i]  <= 1'b0;
        pid[i] <= '0;
        pd[i]  <= '0;
      end
    end else begin
      pv[0]  <= win_any;
      pid[0] <= win_id;
      pd[0]  <= (win_any && !mem_write_en_o) ? mem_data_i : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
        pd[i]  <= pd[i-1];
      end
    end
  end

  assign rsp_valid_o = (!rst && pv[LATENCY-1]) ?
                       (NPORTS'(1) << pid[LATENCY-1]) : '0;
  assign rsp_data_o  = (!rst && pv[LATENCY-1]) ? pd[LATENCY-1] : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter (3 ports, latency 3).
// Arbitration rule in the reference follows MEM_ARB_RR_EN like the DUT build.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NP  = 3;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid_i;
  logic [NP-1:0]    req_ready_o;
  logic [NP*AW-1:0] req_addr_i;
  logic [NP*DW-1:0] req_wdata_i;
  logic [NP-1:0]    req_we_i;
  logic [NP*3-1:0]  req_funct3_i;
  logic [NP-1:0]    rsp_valid_o;
  logic [DW-1:0]    rsp_data_o;
  logic [AW-1:0]    mem_addr_o;
  logic [DW-1:0]    mem_data_o;
  logic             mem_read_en_o;
  logic             mem_write_en_o;
  logic [2:0]       mem_funct3_o;
  logic [DW-1:0]    mem_data_i;

  mem_arbiter #(
    .AWIDTH(AW), .DWIDTH(DW), .NPORTS(NP), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_funct3_o(mem_funct3_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // Environment memory: 16 words, combinational read, write on edge.
  logic [DW-1:0] env_mem [16];
  assign mem_data_i = env_mem[mem_addr_o[5:2]];
  always @(posedge clk)
    if (mem_write_en_o) env_mem[mem_addr_o[5:2]] <= mem_data_o;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [16];
  int            lg_m;
  logic [NP-1:0] hold;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: pick the winner from the arbitration rule, predict the bus.
  task automatic model_check();
    int            w;
    logic [NP-1:0] oh;
    logic [AW-1:0] a;
    logic          we;
    exp_t          e;
    w  = -1;
    oh = '0;
    if (!rst) begin
`ifdef MEM_ARB_RR_EN
      for (int k = 1; k <= NP; k++)
        if (w < 0 && req_valid_i[(lg_m + k) % NP]) w = (lg_m + k) % NP;
`else
      for (int j = 0; j < NP; j++)
        if (w < 0 && req_valid_i[j]) w = j;
`endif
    end
    if (w >= 0) oh[w] = 1'b1;
    chk("ready", req_ready_o, oh);
    if (w >= 0) begin
      a  = req_addr_i[w*AW +: AW];
      we = req_we_i[w];
      chk("mem_addr", mem_addr_o, a);
      chk("mem_data", mem_data_o, req_wdata_i[w*DW +: DW]);
      chk("mem_f3", mem_funct3_o, req_funct3_i[w*3 +: 3]);
      chk("mem_we", mem_write_en_o, we);
      chk("mem_re", mem_read_en_o, !we);
      e.port = w;
      e.data = we ? '0 : ref_mem[a[5:2]];
      e.due  = cyc + LAT;
      q.push_back(e);
      if (we) ref_mem[a[5:2]] = req_wdata_i[w*DW +: DW];
      lg_m = w;
    end else begin
      chk("idle_addr", mem_addr_o, 0);
      chk("idle_data", mem_data_o, 0);
      chk("idle_f3", mem_funct3_o, 0);
      chk("idle_we", mem_write_en_o, 0);
      chk("idle_re", mem_read_en_o, 0);
    end
    if (rst) begin
      q.delete();
      lg_m = NP - 1;
    end
    for (int p = 0; p < NP; p++)
      hold[p] = req_valid_i[p] && !req_ready_o[p];
  endtask

  task automatic drive_cycle(input bit r, input logic [NP-1:0] vmask,
                             input bit rnd);
    int fr;
    @(negedge clk);
    rst = r;
    for (int p = 0; p < NP; p++) begin
      if (!hold[p]) begin
        req_valid_i[p] = rnd ? ($urandom % 3 != 0) : vmask[p];
        req_addr_i[p*AW +: AW] = 32'h0100_0000 + 32'($urandom % 16) * 4;
        req_we_i[p] = ($urandom % 3 == 0);
        req_wdata_i[p*DW +: DW] = $urandom;
        fr = $urandom_range(0, 4);
        req_funct3_i[p*3 +: 3] = req_we_i[p] ? 3'b010 :
                                 3'((fr < 3) ? fr : fr + 1);
      end
    end
    #1 model_check();
  endtask

  // Monitor: every presented response must match the queue head on time.
  always @(negedge clk) begin
    exp_t          e;
    logic [NP-1:0] oh;
    #2;
    if (rsp_valid_o != '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got=%0h want=0 cyc=%0d",
                 rsp_valid_o, cyc);
      end else begin
        e  = q.pop_front();
        oh = '0;
        oh[e.port] = 1'b1;
        chk("rsp_port", rsp_valid_o, oh);
        chk("rsp_data", rsp_data_o, e.data);
        chk("rsp_cycle", cyc, e.due);
      end
    end else begin
      chk("rsp_idle_data", rsp_data_o, 0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing got=none want=port%0d cyc=%0d",
                 e.port, cyc);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    req_valid_i  = '0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_we_i     = '0;
    req_funct3_i = '0;
    hold         = '0;
    lg_m         = NP - 1;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
      ref_mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
    end
    repeat (2) drive_cycle(1'b1, '1, 1'b0);
    repeat (6) drive_cycle(1'b0, '1, 1'b0);
    repeat (400) drive_cycle(1'b0, '0, 1'b1);
    repeat (3) drive_cycle(1'b0, '1, 1'b0);
    drive_cycle(1'b1, '1, 1'b0);
    repeat (6) drive_cycle(1'b0, '1, 1'b0);
    repeat (300) drive_cycle(1'b0, '0, 1'b1);
    repeat (LAT + 8) drive_cycle(1'b0, '0, 1'b0);
    #5;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
